// File: rtl/map_server.sv
// Map-ROM responder: one-bit wall map with a single read port shared by the tracer and the
// overlay under a capped fixed-priority arbiter, plus a bit-serial run-time loader.
module map_server #(
  parameter int unsigned MAP_WIDTH_BITS  = 4,
  parameter int unsigned MAP_HEIGHT_BITS = 4,
  parameter int unsigned TRC_BURST_MAX   = 4
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_trc_req,
  input  logic [MAP_WIDTH_BITS-1:0]  i_trc_col,
  input  logic [MAP_HEIGHT_BITS-1:0] i_trc_row,
  output logic                       o_trc_ack,
  output logic                       o_trc_val,
  input  logic [MAP_WIDTH_BITS-1:0]  i_ovl_col,
  input  logic [MAP_HEIGHT_BITS-1:0] i_ovl_row,
  output logic                       o_ovl_val,
  output logic                       o_ovl_stale,
  input  logic                       i_ld_start,
  input  logic                       i_ld_valid,
  input  logic                       i_ld_bit,
  output logic                       o_ld_busy,
  output logic                       o_ld_done
);

  localparam int unsigned AW    = MAP_WIDTH_BITS + MAP_HEIGHT_BITS;
  localparam int unsigned CELLS = 1 << AW;
  localparam int unsigned W     = 1 << MAP_WIDTH_BITS;
  localparam int unsigned H     = 1 << MAP_HEIGHT_BITS;
  localparam int unsigned BW    = $clog2(TRC_BURST_MAX + 1);

  localparam logic [BW-1:0] BurstMax = BW'(TRC_BURST_MAX);
  localparam logic [AW-1:0] LastCell = AW'(CELLS - 1);

  // Default map: walls around the outer ring, open interior. Index = {row, col}.
  function automatic logic [CELLS-1:0] gen_border();
    logic [CELLS-1:0] m;
    int unsigned r, c;
    m = '0;
    for (int unsigned i = 0; i < CELLS; i++) begin
      r = i / W;
      c = i % W;
      m[i] = (r == 0) || (r == H - 1) || (c == 0) || (c == W - 1);
    end
    return m;
  endfunction

  localparam logic [CELLS-1:0] BorderMap = gen_border();

  typedef enum logic [0:0] {StIdle, StLoad} ld_state_e;

  logic [CELLS-1:0] map_q;
  logic [BW-1:0]    burst_q;
  logic [AW-1:0]    ld_cnt_q;
  ld_state_e        state_q;

  logic          grant_trc;
  logic [AW-1:0] rd_addr;
  logic          rd_bit;
  logic          wr_en;

  always_comb begin
    grant_trc = i_trc_req && (burst_q < BurstMax);
    rd_addr   = grant_trc ? {i_trc_row, i_trc_col} : {i_ovl_row, i_ovl_col};
    rd_bit    = map_q[rd_addr];
    wr_en     = (state_q == StLoad) && i_ld_valid;
  end

  // Read data always comes from the pre-write contents, so same-cycle read/write sees old data.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      o_trc_ack   <= 1'b0;
      o_trc_val   <= 1'b0;
      o_ovl_val   <= 1'b0;
      o_ovl_stale <= 1'b0;
      burst_q     <= '0;
    end else begin
      o_trc_ack   <= grant_trc;
      o_ovl_stale <= grant_trc;
      if (grant_trc) begin
        o_trc_val <= rd_bit;
        burst_q   <= (burst_q == BurstMax) ? burst_q : burst_q + BW'(1);
      end else begin
        o_ovl_val <= rd_bit;
        burst_q   <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      map_q <= BorderMap;
    end else if (wr_en) begin
      map_q[ld_cnt_q] <= i_ld_bit;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      ld_cnt_q  <= '0;
      o_ld_busy <= 1'b0;
      o_ld_done <= 1'b0;
    end else begin
      o_ld_done <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_ld_start) begin
            state_q   <= StLoad;
            ld_cnt_q  <= '0;
            o_ld_busy <= 1'b1;
          end
        end
        StLoad: begin
          if (i_ld_valid) begin
            ld_cnt_q <= ld_cnt_q + AW'(1);
            if (ld_cnt_q == LastCell) begin
              state_q   <= StIdle;
              o_ld_busy <= 1'b0;
              o_ld_done <= 1'b1;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_map_server.sv
// Directed bench for map_server: an array-level reference model checked every cycle, plus
// hand-computed literal checks on the border map, arbitration cap, loader and write/read ordering.
module tb_map_server;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       i_trc_req;
  logic [3:0] i_trc_col, i_trc_row;
  logic       o_trc_ack, o_trc_val;
  logic [3:0] i_ovl_col, i_ovl_row;
  logic       o_ovl_val, o_ovl_stale;
  logic       i_ld_start, i_ld_valid, i_ld_bit;
  logic       o_ld_busy, o_ld_done;

  int n_tests = 0;
  int n_fail  = 0;
  int done_seen = 0;
  int done_before;

  map_server dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_trc_req  (i_trc_req),
    .i_trc_col  (i_trc_col),
    .i_trc_row  (i_trc_row),
    .o_trc_ack  (o_trc_ack),
    .o_trc_val  (o_trc_val),
    .i_ovl_col  (i_ovl_col),
    .i_ovl_row  (i_ovl_row),
    .o_ovl_val  (o_ovl_val),
    .o_ovl_stale(o_ovl_stale),
    .i_ld_start (i_ld_start),
    .i_ld_valid (i_ld_valid),
    .i_ld_bit   (i_ld_bit),
    .o_ld_busy  (o_ld_busy),
    .o_ld_done  (o_ld_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: map as a 2-D array, tracer streak as a plain count.
  bit mm [16][16];
  bit mv = 0;
  bit e_ack, e_tval, e_oval, e_stale, e_busy, e_done;
  int streak, ld_idx;
  bit loading;

  always @(posedge clk) begin
    if (!reset_n) begin
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          mm[r][c] = (r == 0 || r == 15 || c == 0 || c == 15);
      {e_ack, e_tval, e_oval, e_stale, e_busy, e_done} = '0;
      streak = 0; loading = 0; ld_idx = 0; mv = 1;
    end else begin
      e_ack   = i_trc_req && streak < 4;
      e_stale = e_ack;
      if (e_ack) begin
        e_tval = mm[i_trc_row][i_trc_col];
        streak++;
      end else begin
        e_oval = mm[i_ovl_row][i_ovl_col];
        streak = 0;
      end
      e_done = 0;
      if (loading) begin
        if (i_ld_valid) begin
          mm[ld_idx / 16][ld_idx % 16] = i_ld_bit;
          ld_idx++;
          if (ld_idx == 256) begin
            loading = 0; ld_idx = 0; e_done = 1;
          end
        end
      end else if (i_ld_start) begin
        loading = 1; ld_idx = 0;
      end
      e_busy = loading;
    end
  end

  always @(negedge clk) begin
    if (mv) begin
      chk("trc_ack",   o_trc_ack,   e_ack);
      chk("trc_val",   o_trc_val,   e_tval);
      chk("ovl_val",   o_ovl_val,   e_oval);
      chk("ovl_stale", o_ovl_stale, e_stale);
      chk("ld_busy",   o_ld_busy,   e_busy);
      chk("ld_done",   o_ld_done,   e_done);
      if (o_ld_done) done_seen++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ovl_read(input int c, input int r, input logic exp, input string name);
    i_ovl_col = 4'(c);
    i_ovl_row = 4'(r);
    tick();
    chk(name, o_ovl_val, exp);
    chk({name, "_stale"}, o_ovl_stale, 1'b0);
  endtask

  initial begin
    reset_n = 0; i_trc_req = 0; i_trc_col = 0; i_trc_row = 0;
    i_ovl_col = 0; i_ovl_row = 0; i_ld_start = 0; i_ld_valid = 0; i_ld_bit = 0;
    tick(); tick();
    chk("rst_ack", o_trc_ack, 1'b0);
    chk("rst_busy", o_ld_busy, 1'b0);
    chk("rst_stale", o_ovl_stale, 1'b0);
    reset_n = 1;

    // Overlay sweep over the border map
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++) begin
        i_ovl_col = 4'(c); i_ovl_row = 4'(r);
        tick();
      end
    ovl_read(0, 5, 1'b1, "border_0_5");
    ovl_read(7, 7, 1'b0, "border_7_7");

    // Single tracer request at col 15, row 3
    i_trc_req = 1; i_trc_col = 4'd15; i_trc_row = 4'd3;
    tick();
    chk("single_ack", o_trc_ack, 1'b1);
    chk("single_val", o_trc_val, 1'b1);
    chk("single_stale", o_ovl_stale, 1'b1);
    i_trc_req = 0;
    tick();
    chk("single_ack_drop", o_trc_ack, 1'b0);

    // Held request: cap of 4 forces an overlay slot at the 5th and 10th cycles
    i_ovl_col = 4'd0; i_ovl_row = 4'd8;
    for (int i = 0; i < 10; i++) begin
      i_trc_req = 1; i_trc_col = 4'(i); i_trc_row = 4'((i * 3) & 15);
      tick();
      chk("burst_ack", o_trc_ack, (i != 4 && i != 9));
    end
    i_trc_req = 0;
    tick();

    // Checkerboard load, valid every other cycle
    i_ld_start = 1; tick(); i_ld_start = 0;
    chk("load_busy", o_ld_busy, 1'b1);
    for (int k = 0; k < 256; k++) begin
      i_ld_valid = 1; i_ld_bit = 1'(((k / 16) ^ (k % 16)) & 1);
      tick();
      i_ld_valid = 0;
      if (k == 255) begin
        chk("load_done", o_ld_done, 1'b1);
        chk("load_busy_end", o_ld_busy, 1'b0);
      end else begin
        tick();
      end
    end
    tick();
    chk("done_once", 1'(done_seen == 1), 1'b1);
    ovl_read(1, 0, 1'b1, "chk_1_0");
    ovl_read(1, 1, 1'b0, "chk_1_1");

    // Aborted all-ones load with a same-cell read/write at (2,2)
    done_before = done_seen;
    i_ld_start = 1; tick(); i_ld_start = 0;
    for (int k = 0; k < 100; k++) begin
      i_ld_valid = 1; i_ld_bit = 1;
      if (k == 34) begin
        i_trc_req = 1; i_trc_col = 4'd2; i_trc_row = 4'd2;
      end
      if (k == 50) i_ld_start = 1;
      tick();
      i_ld_start = 0;
      if (k == 34) begin
        chk("rw_old_ack", o_trc_ack, 1'b1);
        chk("rw_old_val", o_trc_val, 1'b0);
        i_ld_valid = 0;
        tick();
        chk("rw_new_val", o_trc_val, 1'b1);
        i_trc_req = 0;
      end
      if (k == 60) chk("restart_ignored", o_ld_busy, 1'b1);
    end
    i_ld_valid = 0;
    reset_n = 0;
    tick();
    chk("abort_busy", o_ld_busy, 1'b0);
    reset_n = 1;
    tick();
    ovl_read(2, 2, 1'b0, "abort_2_2");
    ovl_read(5, 0, 1'b1, "abort_5_0");
    ovl_read(3, 4, 1'b0, "abort_3_4");
    for (int i = 0; i < 20; i++) tick();
    chk("abort_no_done", 1'(done_seen == done_before), 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/map_server.md
Name: map_server

Overview:
- Responder side of the map-ROM interface: holds the MAP_WIDTH x MAP_HEIGHT one-bit wall map and answers cell reads.
- Two read requesters: the tracer (req/ack handshake, priority) and the map overlay (free-running column/row address, registered answer).
- Map contents can be replaced at run time by a bit-serial loader.
- Storage behaves as a single-read-port array: exactly one cell read per clock, granted by a fixed-priority arbiter with an overlay anti-starvation cap.

Parameters:
MAP_WIDTH_BITS, 4, log2 of map columns
MAP_HEIGHT_BITS, 4, log2 of map rows
TRC_BURST_MAX, 4, max consecutive tracer grants before one forced overlay grant

Ports:
clk  in  1  system clock
reset_n  in  1  synchronous active-low reset
i_trc_req  in  1  tracer read request; held with address until ack
i_trc_col  in  MAP_WIDTH_BITS  tracer column
i_trc_row  in  MAP_HEIGHT_BITS  tracer row
o_trc_ack  out  1  one-cycle pulse: o_trc_val valid
o_trc_val  out  1  tracer read data (wall=1)
i_ovl_col  in  MAP_WIDTH_BITS  overlay column
i_ovl_row  in  MAP_HEIGHT_BITS  overlay row
o_ovl_val  out  1  overlay read data, registered
o_ovl_stale  out  1  1 = o_ovl_val not refreshed this cycle (tracer held the port)
i_ld_start  in  1  begin serial map load
i_ld_valid  in  1  i_ld_bit valid this cycle
i_ld_bit  in  1  map bit, row-major, row 0 col 0 first
o_ld_busy  out  1  load in progress
o_ld_done  out  1  one-cycle pulse after final bit written

Behaviour:

Reset (reset_n=0 at clk edge):
- All outputs 0; arbiter burst counter 0; loader to IDLE with bit counter 0.
- Map reinitialised to default pattern: cell = 1 when row==0, row==MAP_HEIGHT-1, col==0 or col==MAP_WIDTH-1; else 0.
- Reset mid-load aborts the load; no partial contents survive.

Arbiter (one read per cycle):
- Grant tracer when i_trc_req=1 and burst counter < TRC_BURST_MAX.
  - Next cycle: o_trc_ack=1, o_trc_val=map[i_trc_row][i_trc_col].
  - Burst counter +1 (saturating).
- Otherwise grant overlay.
  - Next cycle: o_ovl_val=map[i_ovl_row][i_ovl_col], o_ovl_stale=0.
  - Burst counter cleared.
- Cycle after a tracer grant: o_ovl_val holds its previous value and o_ovl_stale=1.
- Cycle after an overlay grant: o_trc_ack=0; o_trc_val holds its previous value.
- Forced overlay grant (counter == TRC_BURST_MAX with req high): tracer gets no ack and must keep req and address stable; it is granted the following cycle.
- Tracer holding req continuously receives back-to-back acks, one per granted cycle. Each ack answers the address presented in its grant cycle.
- Read latency is exactly 1 cycle from grant.
- Out-of-range addresses cannot occur; widths match the map.

Loader FSM:
- States: IDLE, LOAD.
- IDLE:
  - i_ld_start=1 -> LOAD, counter=0, o_ld_busy=1 from the next cycle.
  - i_ld_valid is ignored in IDLE.
- LOAD:
  - Each cycle with i_ld_valid=1 writes i_ld_bit to cell index counter (row = counter[MSBs], col = counter[LSBs]), then counter+1.
  - The write of the last cell (index MAP_WIDTH*MAP_HEIGHT-1) returns to IDLE. The next cycle has o_ld_busy=0 and o_ld_done=1 for one cycle.
  - i_ld_start while in LOAD is ignored.
  - If i_ld_start and i_ld_valid are both high in IDLE, only the start takes effect; the bit is dropped.
- Reads continue during LOAD.
- Read and write of the same cell in the same cycle: the read returns the old value; the new value is visible from the next cycle.

Widths: counter is MAP_WIDTH_BITS+MAP_HEIGHT_BITS bits and wraps to 0 on completion; no other arithmetic.

Test Plan:
- Reset, then overlay sweeps (0,0)..(15,15) with tracer idle -> o_ovl_val matches the border pattern 1 cycle later (e.g. (0,5)=1, (7,7)=0); o_ovl_stale=0 throughout.
- Single tracer req at col=15,row=3 -> o_trc_ack=1 and o_trc_val=1 exactly one cycle later; o_ovl_stale=1 in that cycle; ack low otherwise.
- Tracer req held 10 cycles with changing addresses -> acks in cycles 1-4, gap at cycle 5 (o_ovl_stale=0, overlay refreshed), acks resume; every ack value matches its grant-cycle address.
- Load 256 bits of a checkerboard ((row^col)&1) with valid gapped every other cycle -> o_ld_busy high throughout; o_ld_done pulses once after bit 255; overlay reads then return the checkerboard, e.g. (1,0)=1, (1,1)=0.
- Pull reset_n low after 100 load bits -> busy=0, done never pulses, map reads back the border pattern; i_ld_start during LOAD is ignored, so the counter does not restart.
- Tracer reads cell (2,2) in the same cycle the loader writes 1 there (old value 0) -> ack returns 0; a re-read next cycle returns 1.
